// File: rtl/lsu_pkg.sv
// Shared encodings for the MEM-stage load/store unit: micro-op codes,
// exception bit positions, NOP register address and the LSU FSM state type.
// Latency: n/a (declarations only). Backpressure: n/a.
package lsu_pkg;

  localparam int UOP_W = 8;

  localparam logic [UOP_W-1:0] UOP_NOP = 8'h00;
  localparam logic [UOP_W-1:0] UOP_LB  = 8'h10;
  localparam logic [UOP_W-1:0] UOP_LH  = 8'h11;
  localparam logic [UOP_W-1:0] UOP_LW  = 8'h12;
  localparam logic [UOP_W-1:0] UOP_LBU = 8'h13;
  localparam logic [UOP_W-1:0] UOP_LHU = 8'h14;
  localparam logic [UOP_W-1:0] UOP_SB  = 8'h18;
  localparam logic [UOP_W-1:0] UOP_SH  = 8'h19;
  localparam logic [UOP_W-1:0] UOP_SW  = 8'h1a;

  // Bit positions in the 32-bit exception vector (RISC-V cause numbers).
  localparam int EXC_LOAD_MISALIGN  = 4;
  localparam int EXC_LOAD_FAULT     = 5;
  localparam int EXC_STORE_MISALIGN = 6;
  localparam int EXC_STORE_FAULT    = 7;

  localparam logic [4:0]  NOP_REG_A = 5'd0;
  localparam logic [31:0] ZERO_WORD = 32'h0000_0000;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_REQ,
    ST_RESP,
    ST_DONE
  } lsu_state_e;

  function automatic logic [31:0] exc_bit(input int pos);
    return 32'h1 << pos;
  endfunction

endpackage

// File: rtl/lsu_align.sv
// Byte-lane steering for the LSU: byte enables, store data replication,
// load lane extract with sign/zero extension, and misalignment detection.
// Latency: purely combinational. Backpressure: none.
// Ports: uop_i/addr_i/wd_i/rdata_i in; is_load_o/is_store_o/misalign_o/
//        be_o/wdata_o/ld_data_o out.
module lsu_align
  import lsu_pkg::*;
(
  input  logic [UOP_W-1:0] uop_i,
  input  logic [1:0]       addr_i,
  input  logic [31:0]      wd_i,
  input  logic [31:0]      rdata_i,
  output logic             is_load_o,
  output logic             is_store_o,
  output logic             misalign_o,
  output logic [3:0]       be_o,
  output logic [31:0]      wdata_o,
  output logic [31:0]      ld_data_o
);

  logic [7:0]  ld_byte;
  logic [15:0] ld_half;
  logic [3:0]  be_half;

  always_comb begin
    ld_byte    = rdata_i[{addr_i, 3'b000} +: 8];
    ld_half    = addr_i[1] ? rdata_i[31:16] : rdata_i[15:0];
    be_half    = addr_i[1] ? 4'b1100 : 4'b0011;
    is_load_o  = 1'b0;
    is_store_o = 1'b0;
    misalign_o = 1'b0;
    be_o       = 4'b0000;
    wdata_o    = wd_i;
    ld_data_o  = ZERO_WORD;
    case (uop_i)
      UOP_LB, UOP_LBU: begin
        is_load_o = 1'b1;
        be_o      = 4'b0001 << addr_i;
        ld_data_o = {{24{(uop_i == UOP_LB) & ld_byte[7]}}, ld_byte};
      end
      UOP_LH, UOP_LHU: begin
        is_load_o  = 1'b1;
        misalign_o = addr_i[0];
        be_o       = be_half;
        ld_data_o  = {{16{(uop_i == UOP_LH) & ld_half[15]}}, ld_half};
      end
      UOP_LW: begin
        is_load_o  = 1'b1;
        misalign_o = |addr_i;
        be_o       = 4'b1111;
        ld_data_o  = rdata_i;
      end
      UOP_SB: begin
        is_store_o = 1'b1;
        be_o       = 4'b0001 << addr_i;
        wdata_o    = {4{wd_i[7:0]}};
      end
      UOP_SH: begin
        is_store_o = 1'b1;
        misalign_o = addr_i[0];
        be_o       = be_half;
        wdata_o    = {2{wd_i[15:0]}};
      end
      UOP_SW: begin
        is_store_o = 1'b1;
        misalign_o = |addr_i;
        be_o       = 4'b1111;
      end
      default: ;
    endcase
  end

endmodule

// File: rtl/lsu.sv
// MEM-stage load/store unit on a req/gnt/rvalid bus; non-memory uops pass through.
// Latency: 0 for non-memory uops; >=3 cycles for memory uops (REQ+gnt, RESP+rvalid, DONE).
// Backpressure: stall_req_o holds EX/MEM while an access is in flight; dbus_req_o held until gnt.
// Optional bus timeout enabled by defining LSU_BUS_TIMEOUT_EN (TIMEOUT_CYCLES wait limit).
// Ports: clk_i/n_rst_i/flush_i; EX/MEM rd_*/uop/mem_a/mem_wd/csr_*/exception/pc/ins in;
//        dbus_* request/response; MEM/WB rd_*/csr_*/exception/pc/ins out; stall_req_o.
module lsu
  import lsu_pkg::*;
#(
  parameter int TIMEOUT_CYCLES = 256
) (
  input  logic             clk_i,
  input  logic             n_rst_i,
  input  logic             flush_i,
  input  logic             rd_we_i,
  input  logic [4:0]       rd_wa_i,
  input  logic [31:0]      rd_wd_i,
  input  logic [UOP_W-1:0] uop_i,
  input  logic [31:0]      mem_a_i,
  input  logic [31:0]      mem_wd_i,
  input  logic             csr_we_i,
  input  logic [31:0]      csr_wa_i,
  input  logic [31:0]      csr_wd_i,
  input  logic [31:0]      exception_i,
  input  logic [31:0]      pc_i,
  input  logic [31:0]      ins_i,
  output logic             dbus_req_o,
  output logic             dbus_we_o,
  output logic [31:0]      dbus_addr_o,
  output logic [3:0]       dbus_be_o,
  output logic [31:0]      dbus_wdata_o,
  input  logic             dbus_gnt_i,
  input  logic             dbus_rvalid_i,
  input  logic [31:0]      dbus_rdata_i,
  input  logic             dbus_err_i,
  output logic             rd_we_o,
  output logic [4:0]       rd_wa_o,
  output logic [31:0]      rd_wd_o,
  output logic             csr_we_o,
  output logic [31:0]      csr_wa_o,
  output logic [31:0]      csr_wd_o,
  output logic [31:0]      exception_o,
  output logic [31:0]      pc_o,
  output logic [31:0]      ins_o,
  output logic             stall_req_o
);

  lsu_state_e  state_q, state_d;
  logic        discard_q, discard_d;
  logic        err_q, err_d;
  logic [31:0] ld_data_q, ld_data_d;

  logic        is_load, is_store, misalign, is_mem;
  logic [3:0]  be;
  logic [31:0] wdata, ld_ext;
  logic        start, in_req, tmo;

  lsu_align u_align (
    .uop_i      (uop_i),
    .addr_i     (mem_a_i[1:0]),
    .wd_i       (mem_wd_i),
    .rdata_i    (dbus_rdata_i),
    .is_load_o  (is_load),
    .is_store_o (is_store),
    .misalign_o (misalign),
    .be_o       (be),
    .wdata_o    (wdata),
    .ld_data_o  (ld_ext)
  );

  assign is_mem = is_load | is_store;
  // The IDLE cycle that sees a valid memory uop already acts as the REQ cycle,
  // so a same-cycle gnt gives the 3-cycle minimum latency.
  assign start  = n_rst_i && (state_q == ST_IDLE) && is_mem && !misalign &&
                  (exception_i == ZERO_WORD) && !flush_i;
  assign in_req = start || (n_rst_i && (state_q == ST_REQ));

  always_comb begin : fsm_next
    state_d     = state_q;
    discard_d   = discard_q;
    err_d       = err_q;
    ld_data_d   = ld_data_q;
    dbus_req_o  = 1'b0;
    stall_req_o = 1'b0;
    if (in_req) begin
      discard_d   = 1'b0;
      stall_req_o = !flush_i;
      if (flush_i) begin
        state_d = ST_IDLE;
      end else if (tmo) begin
        err_d   = 1'b1;
        state_d = ST_DONE;
      end else begin
        dbus_req_o = 1'b1;
        state_d    = dbus_gnt_i ? ST_RESP : ST_REQ;
      end
    end else if (n_rst_i && (state_q == ST_RESP)) begin
      // A granted request must be drained even when flushed: stay until rvalid.
      stall_req_o = 1'b1;
      if (flush_i) discard_d = 1'b1;
      if (dbus_rvalid_i || tmo) begin
        ld_data_d = ld_ext;
        err_d     = dbus_rvalid_i ? dbus_err_i : 1'b1;
        state_d   = (discard_q || flush_i) ? ST_IDLE : ST_DONE;
      end
    end else if (state_q == ST_DONE) begin
      state_d = ST_IDLE;
    end
  end

  assign dbus_we_o    = dbus_req_o & is_store;
  assign dbus_be_o    = dbus_req_o ? be : 4'b0000;
  assign dbus_addr_o  = {mem_a_i[31:2], 2'b00};
  assign dbus_wdata_o = wdata;

  always_comb begin : wb_out
    rd_we_o     = rd_we_i;
    rd_wa_o     = rd_wa_i;
    rd_wd_o     = rd_wd_i;
    csr_we_o    = csr_we_i;
    csr_wa_o    = csr_wa_i;
    csr_wd_o    = csr_wd_i;
    exception_o = exception_i;
    pc_o        = pc_i;
    ins_o       = ins_i;
    if (exception_i != ZERO_WORD) rd_we_o = 1'b0;
    if ((state_q == ST_IDLE) && is_mem && misalign && (exception_i == ZERO_WORD)) begin
      rd_we_o     = 1'b0;
      exception_o = exception_i | exc_bit(is_store ? EXC_STORE_MISALIGN : EXC_LOAD_MISALIGN);
    end
    // Nothing may retire while the access is outstanding.
    if (stall_req_o) begin
      rd_we_o  = 1'b0;
      csr_we_o = 1'b0;
    end
    if (state_q == ST_DONE) begin
      if (is_load)  rd_wd_o = ld_data_q;
      if (is_store) rd_we_o = 1'b0;
      if (err_q) begin
        rd_we_o     = 1'b0;
        exception_o = exception_i | exc_bit(is_store ? EXC_STORE_FAULT : EXC_LOAD_FAULT);
      end
    end
    if (!n_rst_i || flush_i || ((state_q == ST_RESP) && discard_q)) begin
      rd_we_o     = 1'b0;
      rd_wa_o     = NOP_REG_A;
      rd_wd_o     = ZERO_WORD;
      csr_we_o    = 1'b0;
      csr_wa_o    = ZERO_WORD;
      csr_wd_o    = ZERO_WORD;
      exception_o = ZERO_WORD;
      pc_o        = ZERO_WORD;
      ins_o       = ZERO_WORD;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) begin
      state_q   <= ST_IDLE;
      discard_q <= 1'b0;
      err_q     <= 1'b0;
      ld_data_q <= ZERO_WORD;
    end else begin
      state_q   <= state_d;
      discard_q <= discard_d;
      err_q     <= err_d;
      ld_data_q <= ld_data_d;
    end
  end

`ifdef LSU_BUS_TIMEOUT_EN
  localparam int TMO_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
  localparam logic [TMO_W-1:0] TMO_LAST = TMO_W'(TIMEOUT_CYCLES - 1);

  logic [TMO_W-1:0] tmo_cnt_q, tmo_cnt_d;

  assign tmo = (in_req || (n_rst_i && (state_q == ST_RESP))) && (tmo_cnt_q == TMO_LAST);

  // Counts consecutive cycles in the same wait state; any state change clears it.
  always_comb begin
    tmo_cnt_d = '0;
    if ((in_req && (state_d == ST_REQ)) || ((state_q == ST_RESP) && (state_d == ST_RESP)))
      tmo_cnt_d = tmo_cnt_q + TMO_W'(1);
  end

  always_ff @(posedge clk_i) begin
    if (!n_rst_i) tmo_cnt_q <= '0;
    else          tmo_cnt_q <= tmo_cnt_d;
  end
`else
  logic unused_tmo_param;
  assign tmo              = 1'b0;
  assign unused_tmo_param = ^TIMEOUT_CYCLES;
`endif

endmodule

// File: tb/tb_lsu.sv
// Directed self-checking bench for lsu: reset, pass-through, store lanes,
// load extension, misalignment, bus error, flush drain, back-to-back, timeout.
module tb_lsu;
  import lsu_pkg::*;

  localparam logic [7:0] UOP_ADD = 8'h01;

  logic        clk_i = 1'b0;
  logic        n_rst_i, flush_i, rd_we_i, csr_we_i;
  logic [4:0]  rd_wa_i;
  logic [31:0] rd_wd_i, mem_a_i, mem_wd_i, csr_wa_i, csr_wd_i, exception_i, pc_i, ins_i;
  logic [7:0]  uop_i;
  logic        dbus_gnt_i, dbus_rvalid_i, dbus_err_i;
  logic [31:0] dbus_rdata_i;
  logic        dbus_req_o, dbus_we_o, rd_we_o, csr_we_o, stall_req_o;
  logic [31:0] dbus_addr_o, dbus_wdata_o, rd_wd_o, csr_wa_o, csr_wd_o, exception_o, pc_o, ins_o;
  logic [3:0]  dbus_be_o;
  logic [4:0]  rd_wa_o;

  int errors = 0;
  int checks = 0;

  int          obs_stalls, obs_reqs;
  logic        obs_done, obs_we, obs_fwe;
  logic [3:0]  obs_be;
  logic [31:0] obs_wdata, obs_addr, obs_fwd, obs_fexc;

  always #5 clk_i = ~clk_i;

  lsu #(.TIMEOUT_CYCLES(8)) dut (
    .clk_i(clk_i), .n_rst_i(n_rst_i), .flush_i(flush_i),
    .rd_we_i(rd_we_i), .rd_wa_i(rd_wa_i), .rd_wd_i(rd_wd_i),
    .uop_i(uop_i), .mem_a_i(mem_a_i), .mem_wd_i(mem_wd_i),
    .csr_we_i(csr_we_i), .csr_wa_i(csr_wa_i), .csr_wd_i(csr_wd_i),
    .exception_i(exception_i), .pc_i(pc_i), .ins_i(ins_i),
    .dbus_req_o(dbus_req_o), .dbus_we_o(dbus_we_o), .dbus_addr_o(dbus_addr_o),
    .dbus_be_o(dbus_be_o), .dbus_wdata_o(dbus_wdata_o),
    .dbus_gnt_i(dbus_gnt_i), .dbus_rvalid_i(dbus_rvalid_i),
    .dbus_rdata_i(dbus_rdata_i), .dbus_err_i(dbus_err_i),
    .rd_we_o(rd_we_o), .rd_wa_o(rd_wa_o), .rd_wd_o(rd_wd_o),
    .csr_we_o(csr_we_o), .csr_wa_o(csr_wa_o), .csr_wd_o(csr_wd_o),
    .exception_o(exception_o), .pc_o(pc_o), .ins_o(ins_o),
    .stall_req_o(stall_req_o)
  );

  task automatic set_idle();
    flush_i = 1'b0; rd_we_i = 1'b0; rd_wa_i = 5'd0; rd_wd_i = 32'h0;
    uop_i = UOP_NOP; mem_a_i = 32'h0; mem_wd_i = 32'h0;
    csr_we_i = 1'b0; csr_wa_i = 32'h0; csr_wd_i = 32'h0;
    exception_i = 32'h0; pc_i = 32'h0; ins_i = 32'h0;
    dbus_gnt_i = 1'b0; dbus_rvalid_i = 1'b0; dbus_err_i = 1'b0; dbus_rdata_i = 32'h0;
  endtask

  // Drives one uop against a small bus model (gnt after gnt_dly cycles,
  // rvalid the cycle after gnt) and records what the DUT showed.
  task automatic do_access(input logic [7:0] uop, input logic [31:0] a, input logic [31:0] d,
                           input logic [31:0] rdata, input logic err, input int gnt_dly,
                           input logic [31:0] exc);
    logic granted, rv_next;
    granted = 1'b0; rv_next = 1'b0;
    uop_i = uop; mem_a_i = a; mem_wd_i = d; exception_i = exc;
    rd_we_i = 1'b1; rd_wa_i = 5'd9; rd_wd_i = 32'h5555_5555;
    pc_i = 32'h8000_0000 + a; ins_i = 32'h0000_0013;
    obs_stalls = 0; obs_reqs = 0; obs_done = 1'b0;
    obs_be = 4'h0; obs_wdata = 32'h0; obs_we = 1'b0; obs_addr = 32'h0;
    obs_fwe = 1'b0; obs_fwd = 32'h0; obs_fexc = 32'h0;
    for (int k = 0; k < 40; k++) begin
      dbus_gnt_i    = !granted && (k >= gnt_dly);
      dbus_rvalid_i = rv_next;
      dbus_err_i    = rv_next & err;
      dbus_rdata_i  = rv_next ? rdata : 32'h0;
      @(negedge clk_i);
      if (k == 0) begin
        obs_be = dbus_be_o; obs_wdata = dbus_wdata_o; obs_we = dbus_we_o; obs_addr = dbus_addr_o;
      end
      if (dbus_req_o) obs_reqs++;
      if (stall_req_o) obs_stalls++;
      else begin
        obs_done = 1'b1; obs_fwe = rd_we_o; obs_fwd = rd_wd_o; obs_fexc = exception_o;
      end
      rv_next = dbus_req_o && dbus_gnt_i;
      if (rv_next) granted = 1'b1;
      @(posedge clk_i); #1;
      if (obs_done) break;
    end
    set_idle();
  endtask

  task automatic test_reset();
    set_idle();
    n_rst_i = 1'b0;
    uop_i = UOP_LW; mem_a_i = 32'h40; rd_we_i = 1'b1; rd_wa_i = 5'd3;
    repeat (2) @(posedge clk_i);
    @(negedge clk_i);
    checks++; if (dbus_req_o !== 1'b0) begin errors++; $display("FAIL reset_req got=%b exp=0", dbus_req_o); end
    checks++; if (stall_req_o !== 1'b0) begin errors++; $display("FAIL reset_stall got=%b exp=0", stall_req_o); end
    checks++; if (rd_we_o !== 1'b0) begin errors++; $display("FAIL reset_rd_we got=%b exp=0", rd_we_o); end
    checks++; if (rd_wa_o !== 5'd0) begin errors++; $display("FAIL reset_rd_wa got=%0d exp=0", rd_wa_o); end
    checks++; if (dbus_be_o !== 4'h0 || dbus_we_o !== 1'b0) begin
      errors++; $display("FAIL reset_be_we got be=%h we=%b exp be=0 we=0", dbus_be_o, dbus_we_o); end
    @(posedge clk_i); #1;
    set_idle();
    n_rst_i = 1'b1;
  endtask

  task automatic test_passthrough();
    uop_i = UOP_ADD; rd_we_i = 1'b1; rd_wa_i = 5'd7; rd_wd_i = 32'h1234_5678;
    csr_we_i = 1'b1; csr_wa_i = 32'h300; csr_wd_i = 32'hA5; pc_i = 32'h1000; ins_i = 32'h00a0_0093;
    @(negedge clk_i);
    checks++; if (rd_we_o !== 1'b1 || rd_wa_o !== 5'd7 || rd_wd_o !== 32'h1234_5678) begin
      errors++; $display("FAIL pass_rd got we=%b wa=%0d wd=%h exp 1/7/12345678", rd_we_o, rd_wa_o, rd_wd_o); end
    checks++; if (csr_we_o !== 1'b1 || csr_wa_o !== 32'h300 || csr_wd_o !== 32'hA5) begin
      errors++; $display("FAIL pass_csr got %b/%h/%h exp 1/300/a5", csr_we_o, csr_wa_o, csr_wd_o); end
    checks++; if (pc_o !== 32'h1000 || ins_o !== 32'h00a0_0093 || exception_o !== 32'h0) begin
      errors++; $display("FAIL pass_pc got pc=%h ins=%h exc=%h", pc_o, ins_o, exception_o); end
    checks++; if (stall_req_o !== 1'b0 || dbus_req_o !== 1'b0) begin
      errors++; $display("FAIL pass_stall got stall=%b req=%b exp 0/0", stall_req_o, dbus_req_o); end
    @(posedge clk_i); #1;
    flush_i = 1'b1;
    @(negedge clk_i);
    checks++; if (rd_we_o !== 1'b0 || rd_wa_o !== 5'd0 || csr_we_o !== 1'b0) begin
      errors++; $display("FAIL flush_idle_nop got we=%b wa=%0d csr_we=%b exp 0/0/0", rd_we_o, rd_wa_o, csr_we_o); end
    @(posedge clk_i); #1;
    set_idle();
  endtask

  task automatic test_store();
    do_access(UOP_SW, 32'h100, 32'hDEAD_BEEF, 32'h0, 1'b0, 0, 32'h0);
    checks++; if (obs_be !== 4'b1111 || obs_we !== 1'b1 || obs_addr !== 32'h100 || obs_wdata !== 32'hDEAD_BEEF) begin
      errors++; $display("FAIL sw_bus got be=%b we=%b a=%h d=%h", obs_be, obs_we, obs_addr, obs_wdata); end
    checks++; if (obs_stalls != 2 || obs_reqs != 1 || obs_done !== 1'b1) begin
      errors++; $display("FAIL sw_timing got stalls=%0d reqs=%0d done=%b exp 2/1/1", obs_stalls, obs_reqs, obs_done); end
    checks++; if (obs_fwe !== 1'b0 || obs_fexc !== 32'h0) begin
      errors++; $display("FAIL sw_done got we=%b exc=%h exp 0/0", obs_fwe, obs_fexc); end
    do_access(UOP_SB, 32'h102, 32'h0000_00A5, 32'h0, 1'b0, 0, 32'h0);
    checks++; if (obs_be !== 4'b0100 || obs_wdata !== 32'hA5A5_A5A5 || obs_addr !== 32'h100) begin
      errors++; $display("FAIL sb_lanes got be=%b d=%h a=%h exp 0100/a5a5a5a5/100", obs_be, obs_wdata, obs_addr); end
    do_access(UOP_SH, 32'h102, 32'hFFFF_1234, 32'h0, 1'b0, 0, 32'h0);
    checks++; if (obs_be !== 4'b1100 || obs_wdata !== 32'h1234_1234) begin
      errors++; $display("FAIL sh_lanes got be=%b d=%h exp 1100/12341234", obs_be, obs_wdata); end
  endtask

  task automatic test_load_ext();
    do_access(UOP_LB, 32'h103, 32'h0, 32'h8012_3456, 1'b0, 0, 32'h0);
    checks++; if (obs_fwd !== 32'hFFFF_FF80 || obs_fwe !== 1'b1 || obs_be !== 4'b1000) begin
      errors++; $display("FAIL lb got wd=%h we=%b be=%b exp ffffff80/1/1000", obs_fwd, obs_fwe, obs_be); end
    do_access(UOP_LBU, 32'h103, 32'h0, 32'h8012_3456, 1'b0, 0, 32'h0);
    checks++; if (obs_fwd !== 32'h0000_0080) begin
      errors++; $display("FAIL lbu got wd=%h exp 00000080", obs_fwd); end
    do_access(UOP_LH, 32'h102, 32'h0, 32'h8001_0000, 1'b0, 0, 32'h0);
    checks++; if (obs_fwd !== 32'hFFFF_8001) begin
      errors++; $display("FAIL lh got wd=%h exp ffff8001", obs_fwd); end
    do_access(UOP_LHU, 32'h102, 32'h0, 32'h8001_0000, 1'b0, 0, 32'h0);
    checks++; if (obs_fwd !== 32'h0000_8001) begin
      errors++; $display("FAIL lhu got wd=%h exp 00008001", obs_fwd); end
    do_access(UOP_LW, 32'h108, 32'h0, 32'hCAFE_F00D, 1'b0, 0, 32'h0);
    checks++; if (obs_fwd !== 32'hCAFE_F00D || obs_fwe !== 1'b1 || obs_addr !== 32'h108) begin
      errors++; $display("FAIL lw got wd=%h we=%b a=%h exp cafef00d/1/108", obs_fwd, obs_fwe, obs_addr); end
  endtask

  task automatic test_misalign();
    do_access(UOP_LH, 32'h101, 32'h0, 32'h0, 1'b0, 0, 32'h0);
    checks++; if (obs_reqs != 0 || obs_stalls != 0 || obs_fexc !== 32'h10 || obs_fwe !== 1'b0) begin
      errors++; $display("FAIL lh_misalign got reqs=%0d stalls=%0d exc=%h we=%b exp 0/0/10/0", obs_reqs, obs_stalls, obs_fexc, obs_fwe); end
    do_access(UOP_SW, 32'h102, 32'h1, 32'h0, 1'b0, 0, 32'h0);
    checks++; if (obs_reqs != 0 || obs_fexc !== 32'h40) begin
      errors++; $display("FAIL sw_misalign got reqs=%0d exc=%h exp 0/40", obs_reqs, obs_fexc); end
    do_access(UOP_LW, 32'h100, 32'h0, 32'h0, 1'b0, 0, 32'h4);
    checks++; if (obs_reqs != 0 || obs_stalls != 0 || obs_fexc !== 32'h4 || obs_fwe !== 1'b0) begin
      errors++; $display("FAIL exc_in got reqs=%0d stalls=%0d exc=%h we=%b exp 0/0/4/0", obs_reqs, obs_stalls, obs_fexc, obs_fwe); end
  endtask

  task automatic test_bus_err();
    do_access(UOP_LW, 32'h104, 32'h0, 32'h1234_5678, 1'b1, 3, 32'h0);
    checks++; if (obs_stalls != 5 || obs_reqs != 4) begin
      errors++; $display("FAIL lw_err_timing got stalls=%0d reqs=%0d exp 5/4", obs_stalls, obs_reqs); end
    checks++; if (obs_fexc !== 32'h20 || obs_fwe !== 1'b0) begin
      errors++; $display("FAIL lw_err got exc=%h we=%b exp 20/0", obs_fexc, obs_fwe); end
    do_access(UOP_SW, 32'h104, 32'h9, 32'h0, 1'b1, 0, 32'h0);
    checks++; if (obs_fexc !== 32'h80) begin
      errors++; $display("FAIL sw_err got exc=%h exp 80", obs_fexc); end
  endtask

  task automatic test_flush();
    uop_i = UOP_LW; mem_a_i = 32'h200; rd_we_i = 1'b1; rd_wa_i = 5'd4; dbus_gnt_i = 1'b1;
    @(negedge clk_i);
    checks++; if (dbus_req_o !== 1'b1) begin errors++; $display("FAIL flush_req got=%b exp 1", dbus_req_o); end
    @(posedge clk_i); #1;
    dbus_gnt_i = 1'b0; flush_i = 1'b1;
    @(negedge clk_i);
    checks++; if (stall_req_o !== 1'b1 || rd_we_o !== 1'b0 || dbus_req_o !== 1'b0) begin
      errors++; $display("FAIL flush_hold got stall=%b we=%b req=%b exp 1/0/0", stall_req_o, rd_we_o, dbus_req_o); end
    @(posedge clk_i); #1;
    flush_i = 1'b0; uop_i = UOP_NOP; rd_we_i = 1'b0; dbus_rvalid_i = 1'b1; dbus_rdata_i = 32'h1111_1111;
    @(negedge clk_i);
    checks++; if (stall_req_o !== 1'b1 || rd_we_o !== 1'b0) begin
      errors++; $display("FAIL flush_drain got stall=%b we=%b exp 1/0", stall_req_o, rd_we_o); end
    @(posedge clk_i); #1;
    set_idle();
    do_access(UOP_LBU, 32'h101, 32'h0, 32'h0000_AB00, 1'b0, 0, 32'h0);
    checks++; if (obs_stalls != 2 || obs_fwe !== 1'b1 || obs_fwd !== 32'h0000_00AB) begin
      errors++; $display("FAIL flush_next got stalls=%0d we=%b wd=%h exp 2/1/000000ab", obs_stalls, obs_fwe, obs_fwd); end
  endtask

  task automatic test_back_to_back();
    do_access(UOP_SH, 32'h106, 32'h0000_BEEF, 32'h0, 1'b0, 0, 32'h0);
    checks++; if (obs_stalls != 2 || obs_be !== 4'b1100) begin
      errors++; $display("FAIL b2b_sh got stalls=%0d be=%b exp 2/1100", obs_stalls, obs_be); end
    do_access(UOP_LHU, 32'h106, 32'h0, 32'hBEEF_0000, 1'b0, 0, 32'h0);
    checks++; if (obs_stalls != 2 || obs_reqs != 1 || obs_fwd !== 32'h0000_BEEF) begin
      errors++; $display("FAIL b2b_lhu got stalls=%0d reqs=%0d wd=%h exp 2/1/0000beef", obs_stalls, obs_reqs, obs_fwd); end
  endtask

`ifdef LSU_BUS_TIMEOUT_EN
  task automatic test_timeout();
    do_access(UOP_LW, 32'h300, 32'h0, 32'h0, 1'b0, 1000, 32'h0);
    checks++; if (obs_done !== 1'b1 || obs_stalls != 8 || obs_fexc !== 32'h20 || obs_fwe !== 1'b0) begin
      errors++; $display("FAIL timeout got done=%b stalls=%0d exc=%h we=%b exp 1/8/20/0", obs_done, obs_stalls, obs_fexc, obs_fwe); end
    do_access(UOP_SW, 32'h300, 32'h1, 32'h0, 1'b0, 0, 32'h0);
    checks++; if (obs_stalls != 2 || obs_reqs != 1 || obs_fexc !== 32'h0) begin
      errors++; $display("FAIL timeout_idle got stalls=%0d reqs=%0d exc=%h exp 2/1/0", obs_stalls, obs_reqs, obs_fexc); end
  endtask
`endif

  initial begin
    test_reset();
    test_passthrough();
    test_store();
    test_load_ext();
    test_misalign();
    test_bus_err();
    test_flush();
    test_back_to_back();
`ifdef LSU_BUS_TIMEOUT_EN
    test_timeout();
`endif
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog simulation did not finish errors=%0d checks=%0d", errors, checks);
    $fatal(1);
  end

endmodule
